// File: rtl/cp0_unit.sv
// cp0_unit: coprocessor-0 register file and exception/interrupt arbiter.
// Holds SR(12), Cause(13), EPC(14) and PRId(15) beside the M stage. It raises
// req to flush the pipe and supplies EPC to the fetch mux for eret.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2022_1111,
  parameter logic [31:0] SR_RESET   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  a_rd,
  input  logic [4:0]  a_wr,
  input  logic [31:0] din,
  input  logic        we,
  input  logic        exl_clr,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        req
);

  // Register addresses
  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  // Implemented bits: SR keeps IM[15:10], EXL[1], IE[0];
  // Cause keeps BD[31], IP[15:10], ExcCode[6:2]
  localparam logic [31:0] SR_MASK    = 32'h0000_FC03;
  localparam logic [31:0] CAUSE_MASK = 32'h8000_FC7C;

  localparam int SR_IE      = 0;
  localparam int SR_EXL     = 1;
  localparam int CAUSE_BD   = 31;

  logic [31:0] sr_q,    sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q,   epc_d;

  logic        int_req;
  logic        exc_req;
  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic [31:0] exc_pc;
  logic        epc_write;

  // Force an address onto a word boundary
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

  // Restricted-PC of the faulting instruction: a delay-slot fault restarts at the branch
  function automatic logic [31:0] restart_pc(input logic [31:0] pc, input logic in_slot);
    logic [31:0] pc_sel;
    pc_sel = in_slot ? (pc - 32'd4) : pc;
    return word_align(pc_sel);
  endfunction

  assign sr_im  = sr_q[15:10];
  assign sr_exl = sr_q[SR_EXL];
  assign sr_ie  = sr_q[SR_IE];

  // Requests are masked while a handler runs (EXL=1); interrupts need IE and an enabled line
  always_comb begin
    int_req = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
    exc_req = (exc_code != 5'd0) & ~sr_exl;
    req     = int_req | exc_req;
  end

  assign exc_pc    = restart_pc(pc_m, bd_m);
  assign epc_write = we && (a_wr == ADDR_EPC);

  // EPC bypass lets an eret directly after an mtc0 to EPC use the new value
  always_comb begin
    epc_out = epc_write ? word_align(din) : epc_q;
  end

  // Combinational mfc0 read; unimplemented addresses and bits read as zero
  always_comb begin
    dout = 32'd0;
    case (a_rd)
      ADDR_SR:    dout = sr_q & SR_MASK;
      ADDR_CAUSE: dout = cause_q & CAUSE_MASK;
      ADDR_EPC:   dout = epc_q;
      ADDR_PRID:  dout = PRID_VALUE;
      default:    dout = 32'd0;
    endcase
  end

  // Next-state: exception entry beats mtc0/eret; IP tracks the lines every cycle
  always_comb begin
    sr_d    = sr_q;
    cause_d = cause_q;
    epc_d   = epc_q;

    cause_d[15:10] = hw_int;

    if (req) begin
      sr_d[SR_EXL]      = 1'b1;
      cause_d[CAUSE_BD] = bd_m;
      cause_d[6:2]      = int_req ? 5'd0 : exc_code;
      epc_d             = exc_pc;
    end else begin
      if (we) begin
        case (a_wr)
          ADDR_SR:  sr_d  = din & SR_MASK;
          ADDR_EPC: epc_d = word_align(din);
          default:  ;  // Cause and PRId are read-only to software here
        endcase
      end
      // eret clear wins over a simultaneous write of EXL
      if (exl_clr) begin
        sr_d[SR_EXL] = 1'b0;
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_q    <= SR_RESET & SR_MASK;
      cause_q <= 32'd0;
      epc_q   <= 32'd0;
    end else begin
      sr_q    <= sr_d & SR_MASK;
      cause_q <= cause_d & CAUSE_MASK;
      epc_q   <= epc_d;
    end
  end

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed spec scenarios plus randomized traffic checked against
// a field-level reference model of the CP0 registers.
module tb_cp0_unit;

  localparam logic [31:0] PRID     = 32'h2022_1111;
  localparam logic [31:0] SR_RST   = 32'h0000_0000;

  logic        clk;
  logic        reset;
  logic [4:0]  a_rd;
  logic [4:0]  a_wr;
  logic [31:0] din;
  logic        we;
  logic        exl_clr;
  logic [31:0] pc_m;
  logic        bd_m;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        req;

  int checks = 0;
  int errors = 0;

  // Reference model state, kept as named fields
  logic [5:0]  m_im;
  logic        m_exl;
  logic        m_ie;
  logic        m_bd;
  logic [5:0]  m_ip;
  logic [4:0]  m_exc;
  logic [31:0] m_epc;

  cp0_unit #(.PRID_VALUE(PRID), .SR_RESET(SR_RST)) dut (
    .clk(clk), .reset(reset), .a_rd(a_rd), .a_wr(a_wr), .din(din), .we(we),
    .exl_clr(exl_clr), .pc_m(pc_m), .bd_m(bd_m), .exc_code(exc_code),
    .hw_int(hw_int), .dout(dout), .epc_out(epc_out), .req(req)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_sr();
    return {16'd0, m_im, 8'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, 15'd0, m_ip, 3'd0, m_exc, 2'd0};
  endfunction

  function automatic logic m_int();
    return ((hw_int & m_im) != 6'd0) && m_ie && !m_exl;
  endfunction

  function automatic logic m_excp();
    return (exc_code != 5'd0) && !m_exl;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    case (addr)
      5'd12:   return m_sr();
      5'd13:   return m_cause();
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_im  = SR_RST[15:10];
    m_exl = SR_RST[1];
    m_ie  = SR_RST[0];
    m_bd  = 1'b0;
    m_ip  = 6'd0;
    m_exc = 5'd0;
    m_epc = 32'd0;
  endtask

  task automatic idle_inputs();
    we = 1'b0; exl_clr = 1'b0; a_wr = 5'd0; din = 32'd0;
    exc_code = 5'd0; bd_m = 1'b0; hw_int = 6'd0; pc_m = 32'd0; a_rd = 5'd12;
  endtask

  // Called just after a rising edge with inputs set: check outputs, then advance one edge
  task automatic cycle();
    logic ti, te;
    logic [31:0] exp_epc_out;
    #3;
    ti = m_int();
    te = m_excp();
    exp_epc_out = (we && a_wr == 5'd14) ? (din & 32'hFFFF_FFFC) : m_epc;
    chk("req", {31'd0, req}, {31'd0, ti | te});
    chk("epc_out", epc_out, exp_epc_out);
    chk("dout", dout, m_read(a_rd));
    @(posedge clk);
    m_ip = hw_int;
    if (ti || te) begin
      m_exl = 1'b1;
      m_bd  = bd_m;
      m_exc = ti ? 5'd0 : exc_code;
      m_epc = (bd_m ? pc_m - 32'd4 : pc_m) & 32'hFFFF_FFFC;
    end else begin
      if (we && a_wr == 5'd12) begin
        m_im = din[15:10]; m_exl = din[1]; m_ie = din[0];
      end
      if (we && a_wr == 5'd14) m_epc = din & 32'hFFFF_FFFC;
      if (exl_clr) m_exl = 1'b0;
    end
    #1;
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    a_rd = addr;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic eret();
    idle_inputs();
    exl_clr = 1'b1;
    cycle();
    exl_clr = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_reset();
    reset = 1'b0;
    #1;
    peek("rst_sr", 5'd12, 32'd0);
    peek("rst_cause", 5'd13, 32'd0);
    peek("rst_epc", 5'd14, 32'd0);
    peek("rst_prid", 5'd15, 32'h2022_1111);
    peek("rst_unimpl", 5'd3, 32'd0);
    chk("rst_req", {31'd0, req}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Enable IM/IE then raise line 2
    we = 1'b1; a_wr = 5'd12; din = 32'h0000_FC01;
    cycle();
    idle_inputs();
    hw_int = 6'b000100; pc_m = 32'h0000_1000;
    #1 chk("int_req", {31'd0, req}, 32'd1);
    cycle();
    hw_int = 6'd0;
    peek("int_cause", 5'd13, 32'h0000_1000);
    peek("int_epc", 5'd14, 32'h0000_1000);
    peek("int_sr", 5'd12, 32'h0000_FC03);

    // EXL masks both sources; eret lets the pending interrupt fire
    exc_code = 5'd12; hw_int = 6'b000100;
    #1 chk("exl_block", {31'd0, req}, 32'd0);
    cycle();
    exc_code = 5'd0;
    exl_clr = 1'b1;
    cycle();
    exl_clr = 1'b0;
    #1 chk("int_after_eret", {31'd0, req}, 32'd1);
    cycle();
    eret();

    // Delay-slot exception
    exc_code = 5'd12; bd_m = 1'b1; pc_m = 32'h0000_3008;
    #1 chk("exc_req", {31'd0, req}, 32'd1);
    cycle();
    idle_inputs();
    peek("exc_epc", 5'd14, 32'h0000_3004);
    peek("exc_cause", 5'd13, 32'h8000_0030);
    eret();

    // mtc0 EPC with same-cycle bypass
    we = 1'b1; a_wr = 5'd14; din = 32'h0000_3013;
    #1 chk("epc_bypass", epc_out, 32'h0000_3010);
    cycle();
    idle_inputs();
    peek("epc_write", 5'd14, 32'h0000_3010);

    // Interrupt beats a same-cycle mtc0
    hw_int = 6'b000001; pc_m = 32'h0000_4000;
    we = 1'b1; a_wr = 5'd14; din = 32'h0000_5555;
    cycle();
    idle_inputs();
    peek("int_over_mtc0", 5'd14, 32'h0000_4000);

    // Async reset while in the handler
    reset = 1'b0;
    model_reset();
    #1;
    peek("midrst_epc", 5'd14, 32'd0);
    peek("midrst_sr", 5'd12, 32'd0);
    reset = 1'b1;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      we       = ($urandom_range(0, 3) == 0);
      a_wr     = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      din      = $urandom;
      exl_clr  = ($urandom_range(0, 5) == 0);
      exc_code = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      bd_m     = 1'($urandom);
      pc_m     = ($urandom_range(0, 15) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      hw_int   = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
      a_rd     = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
      if ($urandom_range(0, 59) == 0) begin
        reset = 1'b0;
        model_reset();
        #1;
        chk("rnd_rst_read", dout, m_read(a_rd));
        reset = 1'b1;
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
